sram_responder: RTL and testbench



---
 rtl/sram_responder.sv | 73 +++++++
 tb/tb_sram_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: cache refill memory responder with programmable wait states per
// access phase, write-then-read combined requests and a one-cycle completion pulse.
module sram_responder #(
    parameter int AW  = 16,
    parameter int DW  = 32,
    parameter int LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rdaddress,
    input  logic [AW-1:0] wraddress,
    input  logic [DW-1:0] write_data,
    input  logic          rden,
    input  logic          wren,
    output logic [DW-1:0] read_data,
    output logic          mem_ready,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, DONE} state_t;

    logic [DW-1:0] mem [0:2**AW-1];

    state_t        state, state_nx;
    logic [3:0]    cnt;
    logic          pend;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata;
    logic          term;

    assign term      = cnt == 4'd0;
    assign mem_ready = state == DONE;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = wren ? WR_WAIT : rden ? RD_WAIT : IDLE;
            WR_WAIT: state_nx = term ? (pend ? RD_WAIT : DONE) : WR_WAIT;
            RD_WAIT: state_nx = term ? DONE : RD_WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pend      <= 1'b0;
            waddr     <= '0;
            raddr     <= '0;
            wdata     <= '0;
            read_data <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (wren || rden) cnt <= 4'(LAT - 1);
                pend <= wren && rden;
                if (wren) waddr <= wraddress;
                if (wren) wdata <= write_data;
                if (rden) raddr <= rdaddress;
            end else if (state != DONE) begin
                // reload on the terminal edge so a pending read starts a fresh phase
                cnt <= term ? 4'(LAT - 1) : cnt - 4'd1;
                if (state == RD_WAIT && term) read_data <= mem[raddr];
            end
        end
    end

    // array is never reset; an async reset forces IDLE so no aborted write lands
    always_ff @(posedge clk) begin
        if (state == WR_WAIT && term) mem[waddr] <= wdata;
    end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: scoreboard bench for sram_responder (LAT=3 main instance,
// LAT=1 instance for back-to-back held requests).
module tb_sram_responder;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rdaddress = '0, wraddress = '0;
    logic [31:0] write_data = '0;
    logic        rden = 1'b0, wren = 1'b0;
    logic [31:0] read_data;
    logic        mem_ready, busy;

    logic [15:0] rdaddress1 = '0;
    logic        rden1 = 1'b0;
    logic [31:0] read_data1;
    logic        mem_ready1, busy1;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [logic [15:0]];
    logic [31:0] last_rd = '0;
    int          cyc = 0;
    int          n_vec = 0, n_err = 0;
    logic        done1 = 1'b0;

    sram_responder #(.AW(16), .DW(32), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .rdaddress(rdaddress), .wraddress(wraddress),
        .write_data(write_data), .rden(rden), .wren(wren), .read_data(read_data),
        .mem_ready(mem_ready), .busy(busy)
    );

    sram_responder #(.AW(16), .DW(32), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .rdaddress(rdaddress1), .wraddress(16'h0000),
        .write_data(32'h0), .rden(rden1), .wren(1'b0), .read_data(read_data1),
        .mem_ready(mem_ready1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mem_ready) begin
            chk("ready expected", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("read_data", read_data, e.rdata);
                chk("ready cycle", cyc, e.cyc);
                chk("busy at ready", busy, 1);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle timeout", busy, 0);
    endtask

    task automatic do_req(input logic w, input logic r, input logic [15:0] wa,
                          input logic [15:0] ra, input logic [31:0] wd);
        exp_t e;
        wait_idle();
        wren = w; rden = r; wraddress = wa; rdaddress = ra; write_data = wd;
        e.cyc   = cyc + 1 + ((w && r) ? 2 : 1) * LAT;
        e.rdata = r ? ((w && wa == ra) ? wd : model[ra]) : last_rd;
        last_rd = e.rdata;
        if (w) model[wa] = wd;
        sb.push_back(e);
        @(negedge clk);
        wren = 1'b0; rden = 1'b0;
        chk("busy after accept", busy, 1);
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        dut.mem[a]  = d;
        dut1.mem[a] = d;
        model[a]    = d;
    endtask

    // LAT=1 with rden held: a pulse every 3 cycles, none missed or duplicated
    initial begin
        int c, prev, pulses;
        wait (!rst);
        @(negedge clk);
        rdaddress1 = 16'h0404;
        rden1 = 1'b1;
        c = cyc;
        prev = -1;
        pulses = 0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (mem_ready1) begin
                if (prev < 0) chk("lat1 first pulse", cyc, c + 2);
                else chk("lat1 pulse gap", cyc - prev, 3);
                chk("lat1 read_data", read_data1, 32'hDEADBEEF);
                prev = cyc;
                pulses++;
            end
        end
        rden1 = 1'b0;
        chk("lat1 pulse count", pulses, 7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_ready1) chk("lat1 stray pulse", mem_ready1, 0);
        end
        done1 = 1'b1;
    end

    initial begin
        int t, c;
        preload(16'h0404, 32'hDEADBEEF);
        preload(16'h2404, 32'h24042404);
        preload(16'h0000, 32'h00C0FFEE);
        preload(16'hFFFF, 32'h0BADF00D);
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset mem_ready", mem_ready, 0);
        chk("reset read_data", read_data, 0);
        chk("reset read_data1", read_data1, 0);
        rst = 1'b0;

        do_req(1'b0, 1'b1, 16'h0000, 16'h0404, 32'h0);
        do_req(1'b1, 1'b0, 16'h1000, 16'h0000, 32'h22222222);
        do_req(1'b0, 1'b1, 16'h0000, 16'h1000, 32'h0);
        do_req(1'b1, 1'b1, 16'h2000, 16'h2000, 32'h33333333);
        do_req(1'b1, 1'b1, 16'h0000, 16'h2404, 32'h55555555);
        do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 32'h0);

        // inputs scrambled while the write is in flight must be ignored
        do_req(1'b1, 1'b0, 16'h3000, 16'h0000, 32'h44444444);
        wraddress = 16'hFFFF; rdaddress = 16'hFFFF; write_data = 32'hFFFFFFFF;
        do_req(1'b0, 1'b1, 16'h0000, 16'h3000, 32'h0);
        do_req(1'b0, 1'b1, 16'h0000, 16'hFFFF, 32'h0);

        t = 0;
        while (!done1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("lat1 test finished", done1, 1);

        // reset one cycle before the write's terminal edge
        wait_idle();
        wren = 1'b1; wraddress = 16'h0000; write_data = 32'h11111111;
        c = cyc;
        @(negedge clk);
        wren = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset cycle", cyc, c + 3);
        rst = 1'b1;
        #1;
        chk("mid reset busy", busy, 0);
        chk("mid reset mem_ready", mem_ready, 0);
        chk("mid reset read_data", read_data, 0);
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_ready || busy) chk("post reset quiet", {busy, mem_ready}, 2'b00);
        end
        chk("aborted write", dut.mem[16'h0000], model[16'h0000]);

        do_req(1'b1, 1'b0, 16'h1234, 16'h0000, 32'h66666666);
        do_req(1'b0, 1'b1, 16'h0000, 16'h1234, 32'h0);

        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
